imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. It accepts 32-bit instructions over a valid/ready handshake and produces an XLEN-wide sign- or zero-extended immediate one cycle later through a 2-entry skid buffer. It adds CSR zimm support, XLEN=64, optional opcode-driven format selection, an error flag for unsupported formats, and a pass-through tag for in-order pipeline tracking.

## Interface
- XLEN, 32, datapath width; legal values are 32 and 64.
- AUTO_SEL, 0, format source. 0 selects `imm_sel_in`; 1 derives the format from the opcode and ignores `imm_sel_in`.
- TAG_W, 8, width of the sideband tag.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- flush  in  1  discards all buffered entries.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  the block can accept an instruction this cycle.
- instr_in  in  32  raw instruction word.
- imm_sel_in  in  3  format select; used only when AUTO_SEL=0.
- tag_in  in  TAG_W  sideband tag, carried through unchanged.
- out_valid  out  1  `imm_out` and its sideband outputs are valid.
- out_ready  in  1  downstream accepts the output this cycle.
- imm_out  out  XLEN  generated immediate.
- imm_sel_out  out  3  format that was actually applied.
- tag_out  out  TAG_W  tag of the current output.
- imm_err  out  1  the entry had format 111 or an unknown opcode.

## Operation
- Format encoding:
  - 000 NONE → 0
  - 001 I → sext(instr[31:20])
  - 010 S → sext({instr[31:25], instr[11:7]})
  - 011 B → sext({instr[31], instr[7], instr[30:25], instr[11:8], 0})
  - 100 U → sext({instr[31:12], 12'b0})
  - 101 J → sext({instr[31], instr[19:12], instr[20], instr[30:21], 0})
  - 110 Z → zext(instr[19:15])
  - 111 reserved → 0 with imm_err=1
- Extension rules:
  - Sign extension always uses instr[31].
  - At XLEN=64, U-format results are sign-extended from bit 31.
- AUTO_SEL=1 opcode map (instr[6:0]):
  - 0010011, 0000011, 1100111, 0011011 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J
  - 1110011 → Z if funct3[2]=1, otherwise NONE
  - 0110011, 0111011, 0001111 → NONE
  - any other opcode → NONE with imm_err=1
- The immediate is computed combinationally on input and registered into the skid buffer.
- Skid buffer: a main entry (drives the outputs) and a skid entry. Each entry holds {imm, sel, tag, err, valid}.
- Handshake:
  - A transfer on input happens when in_valid & in_ready; on output when out_valid & out_ready.
  - `in_ready` = !skid.valid, so it is a registered signal with no combinational path from `out_ready`.
  - Accepting while main is empty, or while main is being drained: the new entry goes into main.
  - Accepting while main is held (out_ready=0): the new entry goes into skid.
  - Draining main while skid is valid: skid moves to main and skid is cleared.
  - Simultaneous accept and drain, both entries occupied: not possible, because in_ready=0 then.
- Once out_valid=1, outputs must stay stable until the output transfer completes.
- Flush: both valid bits are cleared next cycle. Flush has priority over a same-cycle accept (the input is dropped) and over a same-cycle drain (the drain is harmless).
- Reset (rst_n=0 at a clock edge):
  - Valid bits clear; out_valid=0 and in_ready=1 from the following cycle.
  - imm_out=0, imm_sel_out=000, tag_out=0, imm_err=0.
  - Reset mid-stream drops all entries.

## Timing
- Latency: an instruction accepted in cycle N appears on `out_valid` in cycle N+1.
- Throughput: 1 instruction per cycle while out_ready=1.
- With out_ready=0, two entries are accepted back-to-back, then in_ready=0.
- After out_ready rises, in_ready returns to 1 one cycle later.
- Combinational paths:
  - The only path is instr_in → imm generation → main/skid D inputs.
  - No combinational path from input to output, or from out_ready to in_ready.

## Structure
- Package `imm_pkg`:
  - `imm_sel_e` enum: IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z, IMM_RSV.
  - Opcode localparams.
  - Entry struct typedef parametrised by XLEN and TAG_W (or a packed width function).
- Sub-module `imm_core`: purely combinational. Inputs instr, sel, XLEN; outputs imm, err. It is reused for the opcode-to-format map.
- The skid-buffer and handshake logic lives in the top `imm_gen_pipe`.

## Test plan
- I-format, XLEN=32, AUTO_SEL=1: instr 0xFFF00093 (addi x1,x0,-1) with tag 0x5A → next cycle imm_out=0xFFFFFFFF, imm_sel_out=001, tag_out=0x5A, imm_err=0.
- S/J formats: 0xFE112E23 (sw x1,-4(x2)) → 0xFFFFFFFC with sel 010; 0xFF9FF06F (jal x0,-8) → 0xFFFFFFF8 with sel 101.
- U-format at XLEN=64: 0x800000B7 (lui x1,0x80000) → 0xFFFFFFFF80000000. CSRRWI with rs1 field = 31 → Z, imm_out=0x1F.
- Backpressure, three back-to-back inputs (tags 1, 2, 3) with out_ready=0 for 3 cycles:
  - in_ready falls after 2 accepts, and tag 3 is held upstream.
  - After out_ready rises, tags come out in order 1, 2, 3 with no loss or duplicate.
- Flush and reset:
  - Flush with 2 entries held plus a simultaneous in_valid → out_valid=0 and in_ready=1 next cycle; nothing from that cycle emerges.
  - rst_n=0 mid-stream → all outputs return to 0.
- Errors:
  - AUTO_SEL=0 with imm_sel_in=111 → imm_out=0, imm_err=1.
  - AUTO_SEL=1 with opcode 1111111 → sel 000, imm_err=1.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the immediate generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imm_pkg;

   // Immediate format codes; the numeric values match the imm_sel_in/imm_sel_out encoding.
   typedef enum logic [2:0] {
      IMM_NONE = 3'b000,
      IMM_I    = 3'b001,
      IMM_S    = 3'b010,
      IMM_B    = 3'b011,
      IMM_U    = 3'b100,
      IMM_J    = 3'b101,
      IMM_Z    = 3'b110,
      IMM_RSV  = 3'b111
   } imm_sel_e;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_REG32  = 7'b0111011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

endpackage

// File: rtl/imm_core.sv
// Combinational immediate extraction: optional opcode->format map, then format->immediate.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no state.
// Ports: i_instr (32b instruction), i_sel (format when AUTO_SEL=0),
//        o_imm (XLEN immediate), o_sel (format applied), o_err (reserved format / unknown opcode).
module imm_core
   import imm_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit AUTO_SEL = 1'b0
) (
   input  logic [31:0]     i_instr,
   input  logic [2:0]      i_sel,
   output logic [XLEN-1:0] o_imm,
   output logic [2:0]      o_sel,
   output logic            o_err
);

   imm_sel_e           w_sel;
   logic               w_map_err;
   logic               w_s;
   logic signed [31:0] w_raw;

   assign w_s = i_instr[31];

   // Format selection: either taken from the port or decoded from the opcode.
   always_comb begin
      w_sel     = imm_sel_e'(i_sel);
      w_map_err = 1'b0;
      if (AUTO_SEL) begin
         case (i_instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_IMM32: w_sel = IMM_I;
            OP_STORE:                           w_sel = IMM_S;
            OP_BRANCH:                          w_sel = IMM_B;
            OP_LUI, OP_AUIPC:                   w_sel = IMM_U;
            OP_JAL:                             w_sel = IMM_J;
            // funct3[2] distinguishes the CSR immediate forms from the register forms.
            OP_SYSTEM:                          w_sel = i_instr[14] ? IMM_Z : IMM_NONE;
            OP_REG, OP_REG32, OP_FENCE:         w_sel = IMM_NONE;
            default: begin
               w_sel     = IMM_NONE;
               w_map_err = 1'b1;
            end
         endcase
      end
   end

   // Every format fits in 32 bits already sign-extended from instr[31] (Z is
   // zero-extended, so its bit 31 is 0); widening to XLEN is then a signed cast.
   always_comb begin
      w_raw = '0;
      case (w_sel)
         IMM_I:   w_raw = {{20{w_s}}, i_instr[31:20]};
         IMM_S:   w_raw = {{20{w_s}}, i_instr[31:25], i_instr[11:7]};
         IMM_B:   w_raw = {{19{w_s}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
         IMM_U:   w_raw = {i_instr[31:12], 12'b0};
         IMM_J:   w_raw = {{11{w_s}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
         IMM_Z:   w_raw = {27'b0, i_instr[19:15]};
         default: w_raw = '0;
      endcase
   end

   assign o_imm = XLEN'(w_raw);
   assign o_sel = w_sel;
   assign o_err = w_map_err | (w_sel == IMM_RSV);

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with a 2-entry skid buffer (main drives outputs, skid absorbs one stall).
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: in_ready = !skid.valid (registered); two entries accepted while stalled, then in_ready drops.
// Ports: clk, rst_n (sync, active-low), flush; in_valid/in_ready/instr_in/imm_sel_in/tag_in upstream;
//        out_valid/out_ready/imm_out/imm_sel_out/tag_out/imm_err downstream.
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int XLEN     = 32,   // 32 or 64
   parameter bit AUTO_SEL = 1'b0,
   parameter int TAG_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr_in,
   input  logic [2:0]       imm_sel_in,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  imm_out,
   output logic [2:0]       imm_sel_out,
   output logic [TAG_W-1:0] tag_out,
   output logic             imm_err
);

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      imm_sel_e         sel;
      logic [TAG_W-1:0] tag;
      logic             err;
      logic             vld;
   } entry_t;

   entry_t          r_main;
   entry_t          r_skid;
   entry_t          w_new;
   logic [XLEN-1:0] w_imm;
   logic [2:0]      w_sel;
   logic            w_err;
   logic            w_accept;
   logic            w_drain;

   imm_core #(
      .XLEN     (XLEN),
      .AUTO_SEL (AUTO_SEL)
   ) u_core (
      .i_instr (instr_in),
      .i_sel   (imm_sel_in),
      .o_imm   (w_imm),
      .o_sel   (w_sel),
      .o_err   (w_err)
   );

   always_comb begin
      w_new     = '0;
      w_new.imm = w_imm;
      w_new.sel = imm_sel_e'(w_sel);
      w_new.tag = tag_in;
      w_new.err = w_err;
      w_new.vld = 1'b1;
   end

   assign in_ready = !r_skid.vld;
   assign w_accept = in_valid & in_ready;
   assign w_drain  = r_main.vld & out_ready;

   // Main is only rewritten when empty or draining, so outputs hold while stalled.
   // Accept and drain with both entries full cannot occur: in_ready is low then.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_main <= '0;
         r_skid <= '0;
      end else if (flush) begin
         r_main.vld <= 1'b0;
         r_skid.vld <= 1'b0;
      end else if (w_drain) begin
         if (r_skid.vld) begin
            r_main     <= r_skid;
            r_skid.vld <= 1'b0;
         end else if (w_accept) begin
            r_main <= w_new;
         end else begin
            r_main.vld <= 1'b0;
         end
      end else if (w_accept) begin
         if (r_main.vld) r_skid <= w_new;
         else            r_main <= w_new;
      end
   end

   assign out_valid   = r_main.vld;
   assign imm_out     = r_main.imm;
   assign imm_sel_out = r_main.sel;
   assign tag_out     = r_main.tag;
   assign imm_err     = r_main.err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, flush, in_valid, out_ready;
   logic [31:0] instr_in;
   logic [2:0]  imm_sel_in;
   logic [7:0]  tag_in;

   // a: XLEN=32 AUTO_SEL=1, b: XLEN=64 AUTO_SEL=1, c: XLEN=32 AUTO_SEL=0; all share inputs.
   logic        rdy_a, vld_a, err_a, rdy_b, vld_b, err_b, rdy_c, vld_c, err_c;
   logic [31:0] imm_a, imm_c;
   logic [63:0] imm_b;
   logic [2:0]  sel_a, sel_b, sel_c;
   logic [7:0]  tag_a, tag_b, tag_c;

   int n_checks = 0;
   int n_pass   = 0;

   imm_gen_pipe #(.XLEN(32), .AUTO_SEL(1'b1), .TAG_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
      .instr_in(instr_in), .imm_sel_in(imm_sel_in), .tag_in(tag_in), .out_valid(vld_a),
      .out_ready(out_ready), .imm_out(imm_a), .imm_sel_out(sel_a), .tag_out(tag_a), .imm_err(err_a));
   imm_gen_pipe #(.XLEN(64), .AUTO_SEL(1'b1), .TAG_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
      .instr_in(instr_in), .imm_sel_in(imm_sel_in), .tag_in(tag_in), .out_valid(vld_b),
      .out_ready(out_ready), .imm_out(imm_b), .imm_sel_out(sel_b), .tag_out(tag_b), .imm_err(err_b));
   imm_gen_pipe #(.XLEN(32), .AUTO_SEL(1'b0), .TAG_W(8)) dut_c (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy_c),
      .instr_in(instr_in), .imm_sel_in(imm_sel_in), .tag_in(tag_in), .out_valid(vld_c),
      .out_ready(out_ready), .imm_out(imm_c), .imm_sel_out(sel_c), .tag_out(tag_c), .imm_err(err_c));

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  sel;
      logic [7:0]  tag;
   } txn_t;

   logic [6:0] ops [13] = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37,
                            7'h17, 7'h6F, 7'h73, 7'h33, 7'h3B, 7'h0F};

   // Reference immediate built by weighting fields arithmetically.
   function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] f, input bit x64);
      longint v;
      logic [63:0] r;
      case (f)
         3'd1: v = longint'(ins[31:20]) - (ins[31] ? 64'sd4096 : 64'sd0);
         3'd2: v = longint'(ins[30:25]) * 32 + longint'(ins[11:7]) - (ins[31] ? 64'sd2048 : 64'sd0);
         3'd3: v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2
                   - (ins[31] ? 64'sd4096 : 64'sd0);
         3'd4: v = longint'(ins[30:12]) * 4096 - (ins[31] ? 64'sd2147483648 : 64'sd0);
         3'd5: v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2
                   - (ins[31] ? 64'sd1048576 : 64'sd0);
         3'd6: v = longint'(ins[19:15]);
         default: v = 0;
      endcase
      r = v;
      if (!x64) r[63:32] = 32'h0;
      return r;
   endfunction

   task automatic ref_auto(input logic [31:0] ins, output logic [2:0] s, output logic e);
      e = 1'b0;
      case (ins[6:0])
         7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011: s = 3'd1;
         7'b0100011: s = 3'd2;
         7'b1100011: s = 3'd3;
         7'b0110111, 7'b0010111: s = 3'd4;
         7'b1101111: s = 3'd5;
         7'b1110011: s = ins[14] ? 3'd6 : 3'd0;
         7'b0110011, 7'b0111011, 7'b0001111: s = 3'd0;
         default: begin s = 3'd0; e = 1'b1; end
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      instr_in = '0; imm_sel_in = '0; tag_in = '0;
      tick(); tick();
      n_checks++; if (vld_a !== 1'b0 || vld_b !== 1'b0 || vld_c !== 1'b0)
         $display("FAIL reset_valid: got %b%b%b want 000", vld_a, vld_b, vld_c); else n_pass++;
      n_checks++; if (rdy_a !== 1'b1 || rdy_b !== 1'b1 || rdy_c !== 1'b1)
         $display("FAIL reset_ready: got %b%b%b want 111", rdy_a, rdy_b, rdy_c); else n_pass++;
      n_checks++; if (imm_a !== 32'h0 || imm_b !== 64'h0 || sel_a !== 3'd0 || tag_a !== 8'h0 || err_a !== 1'b0)
         $display("FAIL reset_outputs: imm=%h/%h sel=%0d tag=%h err=%b want zeros", imm_a, imm_b, sel_a, tag_a, err_a);
      else n_pass++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_i_format();
      out_ready = 1'b1; in_valid = 1'b1; instr_in = 32'hFFF00093; imm_sel_in = 3'b001; tag_in = 8'h5A;
      tick();
      in_valid = 1'b0;
      n_checks++; if (vld_a !== 1'b1) $display("FAIL i_latency: out_valid=%b want 1", vld_a); else n_pass++;
      n_checks++; if (imm_a !== 32'hFFFFFFFF) $display("FAIL i_imm: got %h want ffffffff", imm_a); else n_pass++;
      n_checks++; if (sel_a !== 3'b001 || tag_a !== 8'h5A || err_a !== 1'b0)
         $display("FAIL i_side: sel=%0d tag=%h err=%b want 1 5a 0", sel_a, tag_a, err_a); else n_pass++;
      n_checks++; if (imm_b !== 64'hFFFFFFFFFFFFFFFF) $display("FAIL i_imm64: got %h want all ones", imm_b); else n_pass++;
      n_checks++; if (imm_c !== 32'hFFFFFFFF || sel_c !== 3'b001)
         $display("FAIL i_manual: imm=%h sel=%0d want ffffffff 1", imm_c, sel_c); else n_pass++;
      tick();
   endtask

   task automatic test_s_j();
      out_ready = 1'b1; in_valid = 1'b1; instr_in = 32'hFE112E23; imm_sel_in = 3'b010; tag_in = 8'h01;
      tick();
      n_checks++; if (imm_a !== 32'hFFFFFFFC || sel_a !== 3'b010)
         $display("FAIL s_imm: imm=%h sel=%0d want fffffffc 2", imm_a, sel_a); else n_pass++;
      instr_in = 32'hFF9FF06F; imm_sel_in = 3'b101; tag_in = 8'h02;
      tick();
      in_valid = 1'b0;
      n_checks++; if (imm_a !== 32'hFFFFFFF8 || sel_a !== 3'b101 || tag_a !== 8'h02)
         $display("FAIL j_imm: imm=%h sel=%0d tag=%h want fffffff8 5 02", imm_a, sel_a, tag_a); else n_pass++;
      tick();
      n_checks++; if (vld_a !== 1'b0) $display("FAIL sj_drained: out_valid=%b want 0", vld_a); else n_pass++;
   endtask

   task automatic test_u64_z();
      out_ready = 1'b1; in_valid = 1'b1; instr_in = 32'h800000B7; imm_sel_in = 3'b100; tag_in = 8'h03;
      tick();
      n_checks++; if (imm_b !== 64'hFFFFFFFF80000000 || sel_b !== 3'b100)
         $display("FAIL u_imm64: imm=%h sel=%0d want ffffffff80000000 4", imm_b, sel_b); else n_pass++;
      n_checks++; if (imm_a !== 32'h80000000) $display("FAIL u_imm32: got %h want 80000000", imm_a); else n_pass++;
      instr_in = 32'h300FD073; imm_sel_in = 3'b110; tag_in = 8'h04;   // csrrwi x0, 0x300, 31
      tick();
      in_valid = 1'b0;
      n_checks++; if (imm_b !== 64'h1F || sel_b !== 3'b110 || err_b !== 1'b0)
         $display("FAIL z_imm: imm=%h sel=%0d err=%b want 1f 6 0", imm_b, sel_b, err_b); else n_pass++;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [7:0] got[$];
      logic       acc;
      out_ready = 1'b0; in_valid = 1'b1; instr_in = 32'hFFF00093; imm_sel_in = 3'b001; tag_in = 8'd1;
      tick();
      tag_in = 8'd2;
      tick();
      n_checks++; if (rdy_a !== 1'b0) $display("FAIL bp_ready_low: in_ready=%b want 0", rdy_a); else n_pass++;
      tag_in = 8'd3;
      tick();
      n_checks++; if (rdy_a !== 1'b0 || vld_a !== 1'b1 || tag_a !== 8'd1)
         $display("FAIL bp_hold: ready=%b valid=%b tag=%0d want 0 1 1", rdy_a, vld_a, tag_a); else n_pass++;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (vld_a && out_ready) got.push_back(tag_a);
         acc = in_valid && rdy_a;
         tick();
         if (acc) in_valid = 1'b0;
         if (i == 0) begin
            n_checks++; if (rdy_a !== 1'b1) $display("FAIL bp_ready_return: in_ready=%b want 1", rdy_a); else n_pass++;
         end
      end
      n_checks++; if (got.size() != 3) $display("FAIL bp_count: got %0d outputs want 3", got.size());
      else if (got[0] !== 8'd1 || got[1] !== 8'd2 || got[2] !== 8'd3)
         $display("FAIL bp_order: got %0d,%0d,%0d want 1,2,3", got[0], got[1], got[2]);
      else n_pass++;
   endtask

   task automatic test_flush();
      out_ready = 1'b0; in_valid = 1'b1; instr_in = 32'h00100093; imm_sel_in = 3'b001; tag_in = 8'h10;
      tick();
      tag_in = 8'h11;
      tick();
      tag_in = 8'h12; flush = 1'b1; out_ready = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      n_checks++; if (vld_a !== 1'b0 || rdy_a !== 1'b1)
         $display("FAIL flush_full: valid=%b ready=%b want 0 1", vld_a, rdy_a); else n_pass++;
      tick();
      n_checks++; if (vld_a !== 1'b0) $display("FAIL flush_nothing_emerges: valid=%b tag=%h want 0", vld_a, tag_a); else n_pass++;
      // one entry held, new input would be accepted, but flush drops it
      out_ready = 1'b0; in_valid = 1'b1; tag_in = 8'h20;
      tick();
      tag_in = 8'h21; flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      n_checks++; if (vld_a !== 1'b0 || rdy_a !== 1'b1)
         $display("FAIL flush_accept_drop: valid=%b ready=%b want 0 1", vld_a, rdy_a); else n_pass++;
      tick();
      n_checks++; if (vld_a !== 1'b0) $display("FAIL flush_accept_late: valid=%b tag=%h want 0", vld_a, tag_a); else n_pass++;
   endtask

   task automatic test_errors();
      out_ready = 1'b1; in_valid = 1'b1; instr_in = 32'h1234567F; imm_sel_in = 3'b111; tag_in = 8'h33;
      tick();
      in_valid = 1'b0;
      n_checks++; if (imm_c !== 32'h0 || err_c !== 1'b1 || sel_c !== 3'b111)
         $display("FAIL err_rsv: imm=%h err=%b sel=%0d want 0 1 7", imm_c, err_c, sel_c); else n_pass++;
      n_checks++; if (imm_a !== 32'h0 || err_a !== 1'b1 || sel_a !== 3'b000)
         $display("FAIL err_opcode: imm=%h err=%b sel=%0d want 0 1 0", imm_a, err_a, sel_a); else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0; in_valid = 1'b1; instr_in = 32'hFFF00093; imm_sel_in = 3'b001; tag_in = 8'h44;
      tick();
      tag_in = 8'h45;
      tick();
      rst_n = 1'b0; in_valid = 1'b0;
      tick();
      n_checks++; if (vld_a !== 1'b0 || rdy_a !== 1'b1 || vld_c !== 1'b0)
         $display("FAIL rstmid_valid: valid=%b ready=%b want 0 1", vld_a, rdy_a); else n_pass++;
      n_checks++; if (imm_a !== 32'h0 || imm_b !== 64'h0 || sel_a !== 3'd0 || tag_a !== 8'h0 || err_a !== 1'b0)
         $display("FAIL rstmid_outputs: imm=%h sel=%0d tag=%h err=%b want zeros", imm_a, sel_a, tag_a, err_a);
      else n_pass++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_random();
      txn_t        q[$];
      txn_t        e;
      txn_t        t;
      logic [2:0]  s_auto;
      logic        e_auto;
      logic [63:0] x32, x64, xc;
      int          bad;
      bad = 0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         n_checks++;
         if (rdy_a !== (q.size() < 2) || rdy_b !== (q.size() < 2) || rdy_c !== (q.size() < 2) ||
             vld_a !== (q.size() > 0) || vld_b !== (q.size() > 0) || vld_c !== (q.size() > 0)) begin
            $display("FAIL rnd_handshake cyc %0d: ready=%b%b%b valid=%b%b%b want entries=%0d",
                     cyc, rdy_a, rdy_b, rdy_c, vld_a, vld_b, vld_c, q.size());
         end else n_pass++;
         if (q.size() > 0) begin
            e = q[0];
            ref_auto(e.instr, s_auto, e_auto);
            x32 = ref_imm(e.instr, s_auto, 1'b0);
            x64 = ref_imm(e.instr, s_auto, 1'b1);
            xc  = ref_imm(e.instr, e.sel, 1'b0);
            n_checks++;
            if (imm_a !== x32[31:0] || sel_a !== s_auto || err_a !== e_auto || tag_a !== e.tag)
               $display("FAIL rnd_auto32 instr %h: imm=%h sel=%0d err=%b tag=%h want %h %0d %b %h",
                        e.instr, imm_a, sel_a, err_a, tag_a, x32[31:0], s_auto, e_auto, e.tag);
            else n_pass++;
            n_checks++;
            if (imm_b !== x64 || sel_b !== s_auto || err_b !== e_auto || tag_b !== e.tag)
               $display("FAIL rnd_auto64 instr %h: imm=%h sel=%0d err=%b want %h %0d %b",
                        e.instr, imm_b, sel_b, err_b, x64, s_auto, e_auto);
            else n_pass++;
            n_checks++;
            if (imm_c !== xc[31:0] || sel_c !== e.sel || err_c !== (e.sel == 3'd7) || tag_c !== e.tag)
               $display("FAIL rnd_manual instr %h sel %0d: imm=%h sel=%0d err=%b want %h",
                        e.instr, e.sel, imm_c, sel_c, err_c, xc[31:0]);
            else n_pass++;
         end
         // new stimulus
         in_valid   = ($urandom_range(0, 3) != 0);
         out_ready  = ($urandom_range(0, 2) != 0);
         flush      = ($urandom_range(0, 24) == 0);
         instr_in   = $urandom;
         if ($urandom_range(0, 3) != 0) instr_in[6:0] = ops[$urandom_range(0, 12)];
         imm_sel_in = 3'($urandom_range(0, 7));
         tag_in     = 8'($urandom);
         // model update for the coming edge
         if (flush) begin
            q.delete();
         end else begin
            t.instr = instr_in; t.sel = imm_sel_in; t.tag = tag_in;
            if (in_valid && q.size() < 2) begin
               if (out_ready && q.size() > 0) void'(q.pop_front());
               q.push_back(t);
            end else if (out_ready && q.size() > 0) begin
               void'(q.pop_front());
            end
         end
         tick();
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      tick(); tick(); tick();
      n_checks++; if (vld_a !== 1'b0) $display("FAIL rnd_final_drain: valid=%b want 0", vld_a); else n_pass++;
      if (bad != 0) $display("FAIL rnd_internal: %0d", bad);
   endtask

   initial begin
      test_reset();
      test_i_format();
      test_s_j();
      test_u64_z();
      test_back_to_back();
      test_flush();
      test_errors();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
